// File: rtl/ppu_pkg.sv
// Shared types and helpers for the post-processing unit: config bundle and int8 saturation.
package ppu_pkg;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;
  localparam int CFG_SF_W = 6;
  localparam int CFG_PS_W = 3;

  typedef struct packed {
    logic [CFG_SF_W-1:0] sf;
    logic                round;
    logic                relu;
    logic                pool_en;
    logic [CFG_PS_W-1:0] pool_size;
  } ppu_cfg_t;

  function automatic logic signed [7:0] sat_int8(input longint v);
    if (v > longint'(INT8_MAX)) return 8'sd127;
    if (v < longint'(INT8_MIN)) return -8'sd128;
    return 8'(v);
  endfunction

endpackage

// File: rtl/ppu_quant_lane.sv
// One lane of stage-A math: ReLU, optional round-half-up, arithmetic right shift, int8 saturation.
module ppu_quant_lane
  import ppu_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int SF_W  = 6
) (
  input  logic [ACC_W-1:0] x,
  input  logic [SF_W-1:0]  sf,
  input  logic             round,
  input  logic             relu,
  output logic [OUT_W-1:0] q
);

  logic signed [ACC_W:0] r_ext, biased, shifted;

  always_comb begin
    r_ext   = (relu && x[ACC_W-1]) ? '0 : {x[ACC_W-1], x};
    biased  = r_ext;
    shifted = '0;
    // One guard bit keeps r + 2^(sf-1) from overflowing for every sf up to ACC_W.
    if (round && sf != '0 && int'(sf) <= ACC_W)
      biased = r_ext + ((ACC_W+1)'(1) << (sf - SF_W'(1)));
    // Past ACC_W the rounded value always lands in [0, 2^sf), so only the unrounded sign survives.
    if (int'(sf) > ACC_W)
      shifted = (round || !r_ext[ACC_W]) ? '0 : '1;
    else
      shifted = biased >>> sf;
    q = OUT_W'(sat_int8(longint'(shifted)));
  end

endmodule

// File: rtl/ppu_stream.sv
// Multi-lane post-processing stream: quantise in stage A, optional temporal max-pool in stage B.
module ppu_stream
  import ppu_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 8,
  parameter int SF_W     = CFG_SF_W,
  parameter int POOL_MAX = 4,
  parameter int PS_W     = $clog2(POOL_MAX+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SF_W-1:0]        cfg_sf,
  input  logic                   cfg_round,
  input  logic                   cfg_relu,
  input  logic                   cfg_pool_en,
  input  logic [PS_W-1:0]        cfg_pool_size,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data
);

  localparam int STAGES = 1;

  ppu_cfg_t                    cfg;
  logic                        adv, a_last, close;
  logic [STAGES:0]             vld_pipe;  // [0] stage A, [STAGES] output register
  logic [LANES-1:0][OUT_W-1:0] q, a_q, pmax, upd, o_q;
  logic [PS_W-1:0]             cnt, last_idx;

  assign cfg = '{sf: cfg_sf, round: cfg_round, relu: cfg_relu,
                 pool_en: cfg_pool_en, pool_size: cfg_pool_size};

  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = o_q;
  assign last_idx  = (cfg.pool_size == '0) ? '0 : PS_W'(cfg.pool_size) - PS_W'(1);
  assign close     = a_last || cnt == last_idx;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ppu_quant_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SF_W(SF_W)) u_quant (
      .x     (in_data[i*ACC_W +: ACC_W]),
      .sf    (cfg.sf),
      .round (cfg.round),
      .relu  (cfg.relu),
      .q     (q[i])
    );
    // First beat of a window seeds the maximum regardless of the stale value.
    assign upd[i] = (cnt == '0 || $signed(a_q[i]) > $signed(pmax[i])) ? a_q[i] : pmax[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      a_q      <= '0;
      a_last   <= 1'b0;
      cnt      <= '0;
      pmax     <= '0;
      o_q      <= '0;
    end else if (adv) begin
      vld_pipe[0] <= in_valid;
      if (in_valid) begin
        a_q    <= q;
        a_last <= in_last;
      end
      if (!cfg.pool_en) begin
        vld_pipe[STAGES] <= vld_pipe[0];
        if (vld_pipe[0]) o_q <= a_q;
      end else if (vld_pipe[0]) begin
        pmax             <= upd;
        vld_pipe[STAGES] <= close;
        if (close) begin
          o_q <= upd;
          cnt <= '0;
        end else begin
          cnt <= cnt + PS_W'(1);
        end
      end else begin
        vld_pipe[STAGES] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppu_stream.sv
// Bench for ppu_stream: quantisation vector table, pooling/backpressure/reset sequences, random scoreboard run.
module tb_ppu_stream;
  localparam int LANES = 4, ACC_W = 32, OUT_W = 8, SF_W = 6, POOL_MAX = 4, PS_W = 3;

  logic                   clk = 0, rst = 0;
  logic [SF_W-1:0]        cfg_sf = '0;
  logic                   cfg_round = 0, cfg_relu = 0, cfg_pool_en = 0;
  logic [PS_W-1:0]        cfg_pool_size = '0;
  logic                   in_valid = 0, in_ready, in_last = 0;
  logic [LANES*ACC_W-1:0] in_data = '0;
  logic                   out_valid, out_ready = 1;
  logic [LANES*OUT_W-1:0] out_data;

  ppu_stream #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .SF_W(SF_W), .POOL_MAX(POOL_MAX)) dut (
    .clk(clk), .rst(rst), .cfg_sf(cfg_sf), .cfg_round(cfg_round), .cfg_relu(cfg_relu),
    .cfg_pool_en(cfg_pool_en), .cfg_pool_size(cfg_pool_size), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sf; bit rnd; bit relu;
    int x[LANES];
    int e[LANES];
  } vec_t;

  vec_t        tbl[$];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  int          win_n = 0;
  int          win_max[LANES];
  bit          prev_hold = 0, obs_valid = 0, in_hs = 0, rand_rdy = 0, bp_mode = 0;
  logic [31:0] prev_data = '0, obs_data = '0, last_out = '0;
  int          out_seen = 0, bp_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference quantiser in exact integer arithmetic.
  function automatic int ref_q(input logic [31:0] x, input int sf, input bit rnd, input bit relu);
    longint v;
    v = longint'($signed(x));
    if (relu && v < 0) v = 0;
    if (rnd && sf > 0) v = v + (longint'(1) << (sf - 1));
    v = v >>> sf;
    if (v > 127) return 127;
    if (v < -128) return -128;
    return int'(v);
  endfunction

  function automatic logic [127:0] mk(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic int lane_of(input logic [31:0] w, input int i);
    logic [7:0] b;
    b = w[i*OUT_W +: OUT_W];
    return int'($signed(b));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    win_n = 0; prev_hold = 0; bp_seen = 0;
  endtask

  task automatic model_accept();
    int q[LANES];
    int size;
    logic [31:0] w;
    w = '0;
    size = (cfg_pool_size == 0) ? 1 : int'(cfg_pool_size);
    for (int i = 0; i < LANES; i++)
      q[i] = ref_q(in_data[i*ACC_W +: ACC_W], int'(cfg_sf), cfg_round, cfg_relu);
    if (!cfg_pool_en) begin
      for (int i = 0; i < LANES; i++) w[i*OUT_W +: OUT_W] = 8'(q[i]);
      exp_q.push_back(w);
    end else begin
      for (int i = 0; i < LANES; i++)
        win_max[i] = (win_n == 0 || q[i] > win_max[i]) ? q[i] : win_max[i];
      win_n++;
      if (win_n >= size || in_last) begin
        for (int i = 0; i < LANES; i++) w[i*OUT_W +: OUT_W] = 8'(win_max[i]);
        exp_q.push_back(w);
        win_n = 0;
      end
    end
  endtask

  // Observe one cycle on the falling edge: protocol rules, scoreboard, model update.
  task automatic mon();
    obs_valid = out_valid; obs_data = out_data; in_hs = 0;
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
    end
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (out_valid && !out_ready) bp_seen++;
    if (out_valid && out_ready) begin
      out_seen++; last_out = out_data;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_out: got %0h expected no beat", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %0h expected %0h", out_data, e);
        end
      end
    end
    if (in_valid && in_ready) begin
      in_hs = 1;
      model_accept();
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
  endtask

  task automatic step();
    @(negedge clk); mon();
    @(posedge clk); #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
    else if (bp_mode && bp_seen >= 5) out_ready = 1;
  endtask

  task automatic send(input logic [LANES*ACC_W-1:0] d, input bit last);
    bit ok;
    ok = 0;
    in_valid = 1; in_data = d; in_last = last;
    for (int n = 0; n < 200 && !ok; n++) begin
      step();
      ok = in_hs;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got no handshake expected one within 200 cycles");
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 0; bp_mode = 0; out_ready = 1;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      step();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic add_vec(input int sf, input bit rnd, input bit relu,
                         input int x0, input int x1, input int x2, input int x3,
                         input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.sf = sf; v.rnd = rnd; v.relu = relu;
    v.x = '{x0, x1, x2, x3};
    v.e = '{e0, e1, e2, e3};
    tbl.push_back(v);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 900000");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, total;
    add_vec(4, 0, 0, 1000, 5000, -300, -300,   62, 127,  -19,  -19);
    add_vec(4, 1, 0, 1000, 5000, -300, -300,   63, 127,  -19,  -19);
    add_vec(1, 0, 0, 1000, 5000, -300, -300,  127, 127, -128, -128);
    add_vec(1, 0, 1, 1000, 5000, -300, -300,  127, 127,    0,    0);
    add_vec(0, 0, 0,  127,  128, -128, -129,  127, 127, -128, -128);
    add_vec(32, 0, 0, -1, 1, 32'h8000_0000, 32'h7fff_ffff, -1, 0, -1, 0);
    add_vec(40, 1, 0, -5, 5, 32'h8000_0000, 32'h7fff_ffff,  0, 0,  0, 0);
    add_vec(2, 1, 0,   -2,   -3,    2,    6,    0,  -1,    1,    2);
    add_vec(63, 0, 0,  -1,    0,  100, -100,   -1,   0,    0,   -1);

    rst = 1;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_in_ready", in_ready, 1);
    #5 rst = 0;
    @(posedge clk); #1;

    // Quantisation vectors, also checking the 2-cycle latency.
    foreach (tbl[k]) begin
      cfg_sf = SF_W'(tbl[k].sf); cfg_round = tbl[k].rnd; cfg_relu = tbl[k].relu; cfg_pool_en = 0;
      send(mk(tbl[k].x[0], tbl[k].x[1], tbl[k].x[2], tbl[k].x[3]), 0);
      step(); chk($sformatf("vec%0d_lat1_valid", k), obs_valid, 0);
      step(); chk($sformatf("vec%0d_lat2_valid", k), obs_valid, 1);
      for (int i = 0; i < LANES; i++)
        chk($sformatf("vec%0d_lane%0d", k, i), lane_of(obs_data, i), tbl[k].e[i]);
    end
    step();

    // Pool window of 4.
    cfg_sf = 0; cfg_round = 0; cfg_relu = 0; cfg_pool_en = 1; cfg_pool_size = 4;
    base = out_seen;
    send(mk(3, -1, 0, 0), 0);
    send(mk(-7, -2, 0, 0), 0);
    send(mk(12, -3, 0, 0), 0);
    chk("pool_no_early_out", out_seen - base, 0);
    send(mk(5, -4, 0, 0), 0);
    step(); chk("pool_lat1_valid", obs_valid, 0);
    step(); chk("pool_lat2_valid", obs_valid, 1);
    chk("pool_count", out_seen - base, 1);
    chk("pool_lane0", lane_of(last_out, 0), 12);
    chk("pool_lane1", lane_of(last_out, 1), -1);

    // in_last closes early; next window starts fresh; last on the size-th beat gives one output.
    base = out_seen;
    send(mk(-20, 0, 0, 0), 0);
    send(mk(-9, 0, 0, 0), 1);
    step(); step();
    chk("last_count", out_seen - base, 1);
    chk("last_lane0", lane_of(last_out, 0), -9);
    for (int b = 0; b < 4; b++) send(mk(1, 1, 1, 1), 0);
    step(); step();
    chk("fresh_count", out_seen - base, 2);
    chk("fresh_lane0", lane_of(last_out, 0), 1);
    send(mk(2, 0, 0, 0), 0); send(mk(4, 0, 0, 0), 0);
    send(mk(6, 0, 0, 0), 0); send(mk(8, 0, 0, 0), 1);
    step(); step(); step(); step();
    chk("both_close_count", out_seen - base, 3);
    chk("both_close_lane0", lane_of(last_out, 0), 8);

    // Backpressure: first output held for 5 cycles.
    cfg_pool_en = 0;
    base = out_seen; bp_seen = 0; bp_mode = 1; out_ready = 0;
    for (int b = 0; b < 6; b++) send(mk(10 * b + 1, -b, b, 100), 0);
    chk("bp_hold_cycles", bp_seen, 5);
    drain();
    chk("bp_count", out_seen - base, 6);

    // Asynchronous reset in the middle of a window.
    cfg_pool_en = 1; cfg_pool_size = 4;
    send(mk(50, 50, 50, 50), 0);
    send(mk(60, 60, 60, 60), 0);
    step();
    #2 rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    model_reset();
    #10 rst = 0;
    @(posedge clk); #1;
    base = out_seen;
    for (int b = 0; b < 4; b++) send(mk(7, 7, 7, 7), 0);
    step(); step(); step();
    chk("postrst_count", out_seen - base, 1);
    chk("postrst_data", last_out, 32'h0707_0707);

    // Random episodes; config changes only after each episode drains.
    total = 0;
    while (total < 2000) begin
      int nb;
      cfg_sf        = SF_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 12));
      cfg_round     = 1'($urandom_range(0, 1));
      cfg_relu      = 1'($urandom_range(0, 1));
      cfg_pool_en   = 1'($urandom_range(0, 1));
      cfg_pool_size = PS_W'($urandom_range(0, 4));
      rand_rdy = 1;
      nb = $urandom_range(1, 16);
      for (int b = 0; b < nb; b++) begin
        logic [LANES*ACC_W-1:0] d;
        while ($urandom_range(0, 3) == 0) step();
        for (int i = 0; i < LANES; i++) begin
          case ($urandom_range(0, 2))
            0:       d[i*ACC_W +: ACC_W] = $urandom;
            1:       d[i*ACC_W +: ACC_W] = 32'($urandom_range(0, 8191)) - 32'd4096;
            default: d[i*ACC_W +: ACC_W] = $urandom >> $urandom_range(0, 31);
          endcase
        end
        send(d, (b == nb - 1) || ($urandom_range(0, 5) == 0));
        total++;
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
